// File: rtl/stopwatch_if.sv
// Signal bundle between the button/tick front end and the stopwatch controller.
// Every input is a one-cycle strobe except fast (a level); no back-pressure, every strobe is consumed.
interface stopwatch_if #(
  parameter int CNT_BIT  = 32,
  parameter int SEC_BIT  = 6,
  parameter int MIN_BIT  = 6,
  parameter int HOUR_BIT = 5
);
  logic                start_stop;
  logic                clear;
  logic                lap;
  logic                fast;
  logic                sec_tick;
  logic                run_en;
  logic [CNT_BIT-1:0]  cnt_th;
  logic [SEC_BIT-1:0]  sec;
  logic [MIN_BIT-1:0]  min;
  logic [HOUR_BIT-1:0] hour;
  logic [SEC_BIT-1:0]  lap_sec;
  logic [MIN_BIT-1:0]  lap_min;
  logic [HOUR_BIT-1:0] lap_hour;
  logic                lap_valid;
  logic [1:0]          state;

  modport master (
    output start_stop, clear, lap, fast, sec_tick,
    input  run_en, cnt_th, sec, min, hour, lap_sec, lap_min, lap_hour, lap_valid, state
  );

  modport slave (
    input  start_stop, clear, lap, fast, sec_tick,
    output run_en, cnt_th, sec, min, hour, lap_sec, lap_min, lap_hour, lap_valid, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller: drives the seconds tick generator and keeps
// hh:mm:ss plus a lap snapshot. All outputs come straight from registers.
module stopwatch_ctrl #(
  parameter int CNT_BIT   = 32,
  parameter int SEC_BIT   = 6,
  parameter int MIN_BIT   = 6,
  parameter int HOUR_BIT  = 5,
  parameter int P_CNT_TH  = 100_000_000,
  parameter int P_FAST_TH = 1_000_000
) (
  input logic       clk,
  input logic       reset_n,
  stopwatch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                zero_d;
  logic                run_en_q, run_en_d;
  logic                fast_q;
  logic [CNT_BIT-1:0]  cnt_th_q, cnt_th_d;
  logic [SEC_BIT-1:0]  sec_q, sec_d, lap_sec_q, lap_sec_d;
  logic [MIN_BIT-1:0]  min_q, min_d, lap_min_q, lap_min_d;
  logic [HOUR_BIT-1:0] hour_q, hour_d, lap_hour_q, lap_hour_d;
  logic                lap_valid_q, lap_valid_d;
  logic                tick_ok, lap_ok, fast_chg;

  assign tick_ok  = (state_q == RUN) && bus.sec_tick;
  assign lap_ok   = (state_q == RUN) && bus.lap;
  assign fast_chg = (state_q == RUN) && (bus.fast != fast_q);

  // Clear outranks start_stop outside RUN; inside RUN clear is never honoured.
  always_comb begin
    state_d = state_q;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear)           zero_d  = 1'b1;
        else if (bus.start_stop) state_d = RUN;
      end
      RUN: begin
        if (bus.start_stop) state_d = PAUSE;
      end
      PAUSE: begin
        if (bus.clear) begin
          zero_d  = 1'b1;
          state_d = IDLE;
        end else if (bus.start_stop) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Dropping run_en for one cycle on a fast change restarts the generator count.
  always_comb begin
    run_en_d = (state_d == RUN) && !fast_chg;
    cnt_th_d = bus.fast ? CNT_BIT'(P_FAST_TH) : CNT_BIT'(P_CNT_TH);
  end

  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (zero_d) begin
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (tick_ok) begin
      if (sec_q == SEC_BIT'(59)) begin
        sec_d = '0;
        if (min_q == MIN_BIT'(59)) begin
          min_d  = '0;
          hour_d = (hour_q == HOUR_BIT'(23)) ? '0 : hour_q + HOUR_BIT'(1);
        end else begin
          min_d = min_q + MIN_BIT'(1);
        end
      end else begin
        sec_d = sec_q + SEC_BIT'(1);
      end
    end
  end

  // Lap captures the registered (pre-increment) time.
  always_comb begin
    lap_sec_d   = lap_sec_q;
    lap_min_d   = lap_min_q;
    lap_hour_d  = lap_hour_q;
    lap_valid_d = lap_valid_q;
    if (zero_d) begin
      lap_sec_d   = '0;
      lap_min_d   = '0;
      lap_hour_d  = '0;
      lap_valid_d = 1'b0;
    end else if (lap_ok) begin
      lap_sec_d   = sec_q;
      lap_min_d   = min_q;
      lap_hour_d  = hour_q;
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      run_en_q    <= 1'b0;
      fast_q      <= 1'b0;
      cnt_th_q    <= CNT_BIT'(P_CNT_TH);
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      lap_sec_q   <= '0;
      lap_min_q   <= '0;
      lap_hour_q  <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_en_q    <= run_en_d;
      fast_q      <= bus.fast;
      cnt_th_q    <= cnt_th_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      lap_sec_q   <= lap_sec_d;
      lap_min_q   <= lap_min_d;
      lap_hour_q  <= lap_hour_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.run_en    = run_en_q;
  assign bus.cnt_th    = cnt_th_q;
  assign bus.sec       = sec_q;
  assign bus.min       = min_q;
  assign bus.hour      = hour_q;
  assign bus.lap_sec   = lap_sec_q;
  assign bus.lap_min   = lap_min_q;
  assign bus.lap_hour  = lap_hour_q;
  assign bus.lap_valid = lap_valid_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a tick generator model, a total-seconds reference
// model, and directed plus randomized scenarios.
module tb_stopwatch_ctrl;
  localparam int CNT_TH  = 10;
  localparam int FAST_TH = 2;
  localparam int TW      = 17;

  logic clk;
  logic reset_n;
  logic use_gen;
  logic tb_tick;
  logic gen_tick;
  logic [31:0] gen_cnt;

  int total;
  int bad;

  stopwatch_if #(.CNT_BIT(32), .SEC_BIT(6), .MIN_BIT(6), .HOUR_BIT(5)) bus ();

  stopwatch_ctrl #(
    .CNT_BIT(32), .SEC_BIT(6), .MIN_BIT(6), .HOUR_BIT(5),
    .P_CNT_TH(CNT_TH), .P_FAST_TH(FAST_TH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Tick generator: first tick th edges after run_en rises, then every th clocks.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gen_cnt  <= 32'd0;
      gen_tick <= 1'b0;
    end else if (!bus.run_en) begin
      gen_cnt  <= 32'd0;
      gen_tick <= 1'b0;
    end else if (gen_cnt >= bus.cnt_th - 32'd1) begin
      gen_cnt  <= 32'd0;
      gen_tick <= 1'b1;
    end else begin
      gen_cnt  <= gen_cnt + 32'd1;
      gen_tick <= 1'b0;
    end
  end

  assign bus.sec_tick = use_gen ? gen_tick : tb_tick;

  // ---------------- reference model (time as total seconds of the day) ----------------
  int m_state;
  int m_total;
  int m_lap;
  logic m_lap_valid;
  logic [31:0] m_th;
  logic [TW-1:0] exp_q[$];

  function automatic logic [TW-1:0] pack_time(input int t);
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    h = 5'(t / 3600);
    m = 6'((t / 60) % 60);
    s = 6'(t % 60);
    return {h, m, s};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state     <= 0;
      m_total     <= 0;
      m_lap       <= 0;
      m_lap_valid <= 1'b0;
      m_th        <= 32'(CNT_TH);
    end else begin
      m_th <= bus.fast ? 32'(FAST_TH) : 32'(CNT_TH);
      if (m_state == 1) begin
        if (bus.start_stop) m_state <= 2;
        if (bus.sec_tick) m_total <= (m_total + 1) % 86400;
        if (bus.lap) begin
          m_lap       <= m_total;
          m_lap_valid <= 1'b1;
          exp_q.push_back(pack_time(m_total));
        end
      end else if (bus.clear) begin
        m_state     <= 0;
        m_total     <= 0;
        m_lap       <= 0;
        m_lap_valid <= 1'b0;
      end else if (bus.start_stop) begin
        m_state <= 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n        = 1'b0;
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.lap        = 1'b0;
    bus.fast       = 1'b0;
    tb_tick        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic ss, input logic cl, input logic lp, input logic tk);
    bus.start_stop = ss;
    bus.clear      = cl;
    bus.lap        = lp;
    tb_tick        = tk;
    @(posedge clk);
    #1;
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.lap        = 1'b0;
    tb_tick        = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    use_gen = 1'b0;
    do_reset();
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    total++; if (bus.run_en !== 1'b0) begin bad++; $display("FAIL reset_run_en: got %0b want 0", bus.run_en); end
    total++; if (bus.cnt_th !== 32'(CNT_TH)) begin bad++; $display("FAIL reset_cnt_th: got %0d want %0d", bus.cnt_th, CNT_TH); end
    total++; if ({bus.hour, bus.min, bus.sec} !== 17'd0) begin bad++; $display("FAIL reset_time: got %0d:%0d:%0d want 0:0:0", bus.hour, bus.min, bus.sec); end
    total++; if ({bus.lap_hour, bus.lap_min, bus.lap_sec, bus.lap_valid} !== 18'd0) begin bad++; $display("FAIL reset_lap: got %0d:%0d:%0d v=%0b want 0", bus.lap_hour, bus.lap_min, bus.lap_sec, bus.lap_valid); end
  endtask

  task automatic test_basic_run();
    do_reset();
    use_gen = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bus.state !== 2'd1 || bus.run_en !== 1'b1) begin bad++; $display("FAIL start: state=%0d run_en=%0b want 1/1", bus.state, bus.run_en); end
    repeat (125) @(posedge clk);
    #1;
    total++; if (bus.sec !== 6'd12 || bus.min !== 6'd0) begin bad++; $display("FAIL basic_run_time: got %0d:%0d want 0:12", bus.min, bus.sec); end
    total++; if (bus.state !== 2'd1 || bus.run_en !== 1'b1) begin bad++; $display("FAIL basic_run_state: state=%0d run_en=%0b want 1/1", bus.state, bus.run_en); end
    use_gen = 1'b0;
  endtask

  task automatic test_pause_clear();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bus.state !== 2'd2 || bus.run_en !== 1'b0 || bus.sec !== 6'd3) begin bad++; $display("FAIL pause: state=%0d run_en=%0b sec=%0d want 2/0/3", bus.state, bus.run_en, bus.sec); end
    repeat (4) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (bus.sec !== 6'd3) begin bad++; $display("FAIL pause_ticks_dropped: sec=%0d want 3", bus.sec); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (bus.state !== 2'd0 || {bus.hour, bus.min, bus.sec} !== 17'd0) begin bad++; $display("FAIL clear_in_pause: state=%0d sec=%0d want 0/0", bus.state, bus.sec); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (bus.state !== 2'd1 || bus.sec !== 6'd2 || bus.run_en !== 1'b1) begin bad++; $display("FAIL clear_in_run: state=%0d sec=%0d run_en=%0b want 1/2/1", bus.state, bus.sec, bus.run_en); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (bus.state !== 2'd2 || bus.sec !== 6'd2) begin bad++; $display("FAIL ss_clear_run: state=%0d sec=%0d want 2/2", bus.state, bus.sec); end
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (bus.state !== 2'd0 || bus.sec !== 6'd0) begin bad++; $display("FAIL ss_clear_pause: state=%0d sec=%0d want 0/0", bus.state, bus.sec); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    total++; if (bus.state !== 2'd2 || bus.sec !== 6'd2) begin bad++; $display("FAIL ss_with_tick: state=%0d sec=%0d want 2/2", bus.state, bus.sec); end
  endtask

  task automatic test_lap();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    total++; if ({bus.lap_hour, bus.lap_min, bus.lap_sec} !== 17'd7 || bus.lap_valid !== 1'b1) begin bad++; $display("FAIL lap_capture: got %0d:%0d:%0d v=%0b want 0:0:7 v=1", bus.lap_hour, bus.lap_min, bus.lap_sec, bus.lap_valid); end
    total++; if (bus.sec !== 6'd8) begin bad++; $display("FAIL lap_tick_sec: sec=%0d want 8", bus.sec); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (bus.lap_sec !== 6'd7 || bus.lap_valid !== 1'b1) begin bad++; $display("FAIL lap_in_pause: lap_sec=%0d v=%0b want 7/1", bus.lap_sec, bus.lap_valid); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (bus.lap_sec !== 6'd0 || bus.lap_valid !== 1'b0) begin bad++; $display("FAIL lap_clear: lap_sec=%0d v=%0b want 0/0", bus.lap_sec, bus.lap_valid); end
  endtask

  task automatic test_fast_toggle();
    do_reset();
    use_gen = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.fast = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.run_en !== 1'b0 || bus.cnt_th !== 32'(FAST_TH) || bus.state !== 2'd1) begin bad++; $display("FAIL fast_restart: run_en=%0b cnt_th=%0d state=%0d want 0/%0d/1", bus.run_en, bus.cnt_th, bus.state, FAST_TH); end
    @(posedge clk); #1;
    total++; if (bus.run_en !== 1'b1) begin bad++; $display("FAIL fast_rerise: run_en=%0b want 1", bus.run_en); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.sec !== 6'd0) begin bad++; $display("FAIL fast_no_early_tick: sec=%0d want 0", bus.sec); end
    @(posedge clk); #1;
    total++; if (bus.sec !== 6'd1) begin bad++; $display("FAIL fast_first_tick: sec=%0d want 1", bus.sec); end
    bus.fast = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.run_en !== 1'b0 || bus.cnt_th !== 32'(CNT_TH)) begin bad++; $display("FAIL slow_restart: run_en=%0b cnt_th=%0d want 0/%0d", bus.run_en, bus.cnt_th, CNT_TH); end
    @(posedge clk); #1;
    total++; if (bus.run_en !== 1'b1) begin bad++; $display("FAIL slow_rerise: run_en=%0b want 1", bus.run_en); end
    // reset asserted mid-run must clear everything without waiting for a clock
    bus.fast = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    total++; if (bus.state !== 2'd0 || bus.run_en !== 1'b0 || bus.cnt_th !== 32'(CNT_TH)) begin bad++; $display("FAIL async_reset_ctrl: state=%0d run_en=%0b cnt_th=%0d want 0/0/%0d", bus.state, bus.run_en, bus.cnt_th, CNT_TH); end
    total++; if ({bus.hour, bus.min, bus.sec, bus.lap_hour, bus.lap_min, bus.lap_sec, bus.lap_valid} !== 35'd0) begin bad++; $display("FAIL async_reset_time: sec=%0d lap_sec=%0d v=%0b want 0", bus.sec, bus.lap_sec, bus.lap_valid); end
    use_gen = 1'b0;
    do_reset();
  endtask

  task automatic test_wrap();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tb_tick = 1'b1;
    for (int i = 1; i <= 86398; i++) begin
      @(posedge clk);
      #1;
      if (i == 59) begin
        total++; if ({bus.hour, bus.min, bus.sec} !== {5'd0, 6'd0, 6'd59}) begin bad++; $display("FAIL wrap_59: got %0d:%0d:%0d want 0:0:59", bus.hour, bus.min, bus.sec); end
      end
      if (i == 60) begin
        total++; if ({bus.hour, bus.min, bus.sec} !== {5'd0, 6'd1, 6'd0}) begin bad++; $display("FAIL min_carry: got %0d:%0d:%0d want 0:1:0", bus.hour, bus.min, bus.sec); end
      end
      if (i == 3600) begin
        total++; if ({bus.hour, bus.min, bus.sec} !== {5'd1, 6'd0, 6'd0}) begin bad++; $display("FAIL hour_carry: got %0d:%0d:%0d want 1:0:0", bus.hour, bus.min, bus.sec); end
      end
    end
    tb_tick = 1'b0;
    total++; if ({bus.hour, bus.min, bus.sec} !== {5'd23, 6'd59, 6'd58}) begin bad++; $display("FAIL preload: got %0d:%0d:%0d want 23:59:58", bus.hour, bus.min, bus.sec); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if ({bus.hour, bus.min, bus.sec} !== {5'd23, 6'd59, 6'd59}) begin bad++; $display("FAIL last_second: got %0d:%0d:%0d want 23:59:59", bus.hour, bus.min, bus.sec); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if ({bus.hour, bus.min, bus.sec} !== 17'd0) begin bad++; $display("FAIL day_wrap: got %0d:%0d:%0d want 0:0:0", bus.hour, bus.min, bus.sec); end
  endtask

  task automatic test_random();
    logic [TW-1:0] exp_lap;
    logic [TW-1:0] exp_now;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      bus.start_stop = ($urandom_range(0, 7) == 0);
      bus.clear      = ($urandom_range(0, 7) == 0);
      bus.lap        = ($urandom_range(0, 5) == 0);
      tb_tick        = ($urandom_range(0, 1) == 1);
      @(posedge clk);
      #1;
      exp_now = pack_time(m_total);
      total++; if (bus.state !== 2'(m_state)) begin bad++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, bus.state, m_state); end
      total++; if ({bus.hour, bus.min, bus.sec} !== exp_now) begin bad++; $display("FAIL rnd_time[%0d]: got %0d:%0d:%0d want total %0d s", i, bus.hour, bus.min, bus.sec, m_total); end
      total++; if (bus.run_en !== (m_state == 1) || bus.cnt_th !== m_th) begin bad++; $display("FAIL rnd_run_en[%0d]: run_en=%0b cnt_th=%0d want %0b/%0d", i, bus.run_en, bus.cnt_th, (m_state == 1), m_th); end
      total++; if (bus.lap_valid !== m_lap_valid) begin bad++; $display("FAIL rnd_lap_valid[%0d]: got %0b want %0b", i, bus.lap_valid, m_lap_valid); end
      if (exp_q.size() > 0) begin
        exp_lap = exp_q.pop_front();
        total++; if ({bus.lap_hour, bus.lap_min, bus.lap_sec} !== exp_lap) begin bad++; $display("FAIL rnd_lap[%0d]: got %0d:%0d:%0d want packed %0h", i, bus.lap_hour, bus.lap_min, bus.lap_sec, exp_lap); end
      end
    end
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.lap        = 1'b0;
    tb_tick        = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total   = 0;
    bad     = 0;
    use_gen = 1'b0;
    test_reset();
    test_basic_run();
    test_pause_clear();
    test_simultaneous();
    test_lap();
    test_fast_toggle();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
